seq_frame_scanner: RTL and testbench



---
 rtl/seq_frame_scanner_pkg.sv | 16 +
 rtl/seq_frame_scanner_mealy_core.sv | 45 ++++
 rtl/seq_frame_scanner.sv | 123 ++++++++++++
 tb/tb_seq_frame_scanner.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/seq_frame_scanner_pkg.sv
// Shared definitions for the word-to-bit-serial sequence scanner.
// Holds the controller state encoding and small helpers used by the top.
package seq_frame_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  // Busy covers every state in which a word is owned by the scanner.
  function automatic logic state_busy(input state_e s);
    return (s == ST_SHIFT) || (s == ST_REPORT);
  endfunction

endpackage

// File: rtl/seq_frame_scanner_mealy_core.sv
// Bit-serial Mealy detector: history window, valid-depth tracking and match logic.
// The depth counter keeps a freshly cleared history from matching zero-heavy patterns early.
module seq_mealy_core #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b0100,
  parameter bit               OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic shift_en,
  input  logic x,
  output logic hit
);

  localparam int               DEPTH_W    = $clog2(PAT_W);
  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(PAT_W - 1);

  logic [PAT_W-2:0]   hist;
  logic [DEPTH_W-1:0] depth;
  logic [PAT_W-1:0]   window;

  assign window = {hist, x};
  assign hit    = shift_en && (depth == DEPTH_FULL) && (window == PATTERN);

  // History and depth update; a match in non-overlap mode restarts from empty.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist  <= '0;
      depth <= '0;
    end else if (shift_en) begin
      if (hit && !OVERLAP) begin
        hist  <= '0;
        depth <= '0;
      end else begin
        hist  <= window[PAT_W-2:0];
        depth <= (depth == DEPTH_FULL) ? depth : depth + DEPTH_W'(1);
      end
    end else begin
      hist  <= hist;
      depth <= depth;
    end
  end

endmodule

// File: rtl/seq_frame_scanner.sv
// Word-level controller: accepts a word, serialises it MSB-first into the
// Mealy core one bit per clock, counts hits and returns the count over a handshake.
module seq_frame_scanner
  import seq_frame_scanner_pkg::*;
#(
  parameter int               WORD_W  = 16,
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b0100,
  parameter bit               OVERLAP = 1'b1,
  localparam int              CNT_W   = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_first,
  output logic              det_x,
  output logic              det_hit,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count
);

  localparam int               BIT_W    = $clog2(WORD_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WORD_W);

  state_e            state;
  logic [WORD_W-1:0] sreg;
  logic [BIT_W-1:0]  bitcnt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              in_ready_r;
  logic              res_valid_r;
  logic              busy_r;
  logic [CNT_W-1:0]  res_count_r;
  logic              accept;
  logic              core_clr;
  logic              core_shift;
  logic              core_hit;

  assign accept     = (state == ST_IDLE) && in_valid && in_ready_r;
  assign core_clr   = accept && in_first;
  assign core_shift = (state == ST_SHIFT);
  assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  assign det_x      = core_shift ? sreg[WORD_W-1] : 1'b0;
  assign det_hit    = core_hit;
  assign in_ready   = in_ready_r;
  assign res_valid  = res_valid_r;
  assign busy       = busy_r;
  assign res_count  = res_count_r;

  seq_mealy_core #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clr      (core_clr),
    .shift_en (core_shift),
    .x        (det_x),
    .hit      (core_hit)
  );

  // Controller FSM with registered handshake, busy and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      sreg        <= '0;
      bitcnt      <= '0;
      cnt         <= '0;
      in_ready_r  <= 1'b1;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      res_count_r <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sreg       <= in_data;
            bitcnt     <= '0;
            cnt        <= '0;
            state      <= ST_SHIFT;
            in_ready_r <= 1'b0;
            busy_r     <= state_busy(ST_SHIFT);
          end
        end
        ST_SHIFT: begin
          sreg   <= {sreg[WORD_W-2:0], 1'b0};
          bitcnt <= bitcnt + BIT_W'(1);
          if (core_hit) begin
            cnt <= cnt_inc;
          end
          // The final bit's hit must land in the reported count on the same edge.
          if (bitcnt == LAST_BIT) begin
            state       <= ST_REPORT;
            res_valid_r <= 1'b1;
            res_count_r <= core_hit ? cnt_inc : cnt;
          end
        end
        ST_REPORT: begin
          if (res_ready) begin
            state       <= ST_IDLE;
            res_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= state_busy(ST_IDLE);
          end
        end
        default: begin
          state       <= ST_IDLE;
          in_ready_r  <= 1'b1;
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frame_scanner.sv
// Directed bench for seq_frame_scanner: an overlap and a non-overlap instance share stimulus.
module tb_seq_frame_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_first;
  logic        res_ready;

  logic        in_ready,  det_x,  det_hit,  busy,  res_valid;
  logic [4:0]  res_count;
  logic        in_ready_n, det_x_n, det_hit_n, busy_n, res_valid_n;
  logic [4:0]  res_count_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_frame_scanner #(.WORD_W(16), .PAT_W(4), .PATTERN(4'b0100), .OVERLAP(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_first(in_first), .det_x(det_x), .det_hit(det_hit), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count)
  );

  seq_frame_scanner #(.WORD_W(16), .PAT_W(4), .PATTERN(4'b0100), .OVERLAP(1'b0)) dut_no (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data),
    .in_first(in_first), .det_x(det_x_n), .det_hit(det_hit_n), .busy(busy_n),
    .res_valid(res_valid_n), .res_ready(res_ready), .res_count(res_count_n)
  );

  typedef struct {
    logic [15:0] data;
    logic        first;
    logic [15:0] hits;
    int          count;
    int          count_no;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_wait actual=0 expected=1");
    end
  endtask

  // Accept one word, record det_x/det_hit per bit, check latency, counts and handshake.
  task automatic run_word(input logic [15:0] data, input logic first, input logic [15:0] hits,
                          input int count, input int count_no, input int stall);
    logic [15:0] xs, hs, exp_x;
    int lat;
    xs = '0; hs = '0; lat = 0;
    for (int i = 0; i < 16; i++) exp_x[i] = data[15-i];
    wait_ready();
    res_ready = (stall == 0);
    in_data   = data;
    in_first  = first;
    in_valid  = 1'b1;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        in_valid = 1'b0;
        chk("busy_in_shift", {31'd0, busy}, 32'd1);
      end
      if (n <= 16) begin
        xs[n-1] = det_x;
        hs[n-1] = det_hit;
      end
      if (res_valid) lat = n;
    end
    chk("latency", lat, 32'd17);
    chk("det_x_stream", {16'd0, xs}, {16'd0, exp_x});
    chk("det_hit_bits", {16'd0, hs}, {16'd0, hits});
    chk("res_count", {27'd0, res_count}, count);
    chk("res_count_no_overlap", {27'd0, res_count_n}, count_no);
    for (int s = 0; s < stall; s++) begin
      chk("stall_res_valid", {31'd0, res_valid}, 32'd1);
      chk("stall_res_count", {27'd0, res_count}, count);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      in_data  = 16'hFFFF;
      in_valid = 1'b1;
      @(negedge clk);
    end
    res_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("post_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_res_valid", {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'h4880, 1'b1, 16'h0448, 3, 2};
    vecs[1] = '{16'h0002, 1'b1, 16'h0000, 0, 0};
    vecs[2] = '{16'h0000, 1'b0, 16'h0001, 1, 1};
    vecs[3] = '{16'h0002, 1'b1, 16'h0000, 0, 0};
    vecs[4] = '{16'h0000, 1'b1, 16'h0000, 0, 0};
    vecs[5] = '{16'h4444, 1'b1, 16'h8888, 4, 4};
    vecs[6] = '{16'h0000, 1'b1, 16'h0000, 0, 0};
    vecs[7] = '{16'hFFFF, 1'b1, 16'h0000, 0, 0};

    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; in_first = 1'b0; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_count", {27'd0, res_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_det_x", {31'd0, det_x}, 32'd0);
    chk("rst_det_hit", {31'd0, det_hit}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++)
      run_word(vecs[v].data, vecs[v].first, vecs[v].hits, vecs[v].count, vecs[v].count_no, 0);

    // Consumer stalls five cycles in REPORT while the producer offers another word.
    run_word(16'h4444, 1'b1, 16'h8888, 4, 4, 5);

    // Reset in the middle of SHIFT, then a word without in_first must see clean history.
    wait_ready();
    in_data = 16'h4880; in_first = 1'b1; in_valid = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_det_x", {31'd0, det_x}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_word(16'h0400, 1'b0, 16'h0080, 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
